// File: rtl/sa_pkg.sv
// Shared systolic-array defaults and the packed result-vector type used by the
// input-skew feeder and the output deskew collector.
package sa_pkg;

    localparam int unsigned SA_SIZE       = 4;
    localparam int unsigned SA_ACC_WIDTH  = 16;
    localparam int unsigned SA_FIFO_DEPTH = 4;

    typedef logic [SA_SIZE-1:0][SA_ACC_WIDTH-1:0] acc_vec_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop frees a slot in the same cycle,
// so push and pop together while full both succeed.
module sa_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sa_output_deskew.sv
// Realigns the staggered bottom-row partial sums into full-width vectors and
// queues them for downstream on a valid/ready handshake.
module sa_output_deskew
    import sa_pkg::*;
#(
    parameter int unsigned Size      = SA_SIZE,
    parameter int unsigned AccWidth  = SA_ACC_WIDTH,
    parameter int unsigned FifoDepth = SA_FIFO_DEPTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    input  logic [Size-1:0][AccWidth-1:0]      acc_in_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [Size-1:0][AccWidth-1:0]      out_data_o,
    output logic [$clog2(FifoDepth):0]         level_o,
    output logic                               overflow_o,
    input  logic                               clr_overflow_i
);

    logic [Size-1:0][AccWidth-1:0] aligned;
    logic [Size-1:1]               vld_q;
    logic                          push, pop, full, empty, drop;
    logic                          overflow_q, overflow_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[1] <= in_valid_i;
            for (int k = 2; k < Size; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Column j arrives j cycles late, so it needs Size-1-j stages to line up.
    for (genvar j = 0; j < Size - 1; j++) begin : g_dly
        localparam int unsigned Stages = Size - 1 - j;
        logic [AccWidth-1:0] dly_q [Stages];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < Stages; k++) begin
                    dly_q[k] <= '0;
                end
            end else begin
                dly_q[0] <= acc_in_i[j];
                for (int k = 1; k < Stages; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end

        assign aligned[j] = dly_q[Stages-1];
    end

    assign aligned[Size-1] = acc_in_i[Size-1];

    assign push        = vld_q[Size-1];
    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign drop        = push && full && !pop;

    sa_sync_fifo #(
        .Width (Size * AccWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (aligned),
        .rdata_o (out_data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_sa_output_deskew.sv
// Randomized and directed bench for sa_output_deskew, scored against a
// cycle-history model of the skew contract and a queue-based FIFO.
module tb_sa_output_deskew;

    localparam int unsigned Size      = 4;
    localparam int unsigned AccWidth  = 16;
    localparam int unsigned FifoDepth = 4;
    localparam int unsigned LvlW      = $clog2(FifoDepth) + 1;
    localparam int unsigned HistLen   = 64;

    typedef logic [Size-1:0][AccWidth-1:0] vec_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    vec_t            acc_in;
    logic            out_valid;
    logic            out_ready;
    vec_t            out_data;
    logic [LvlW-1:0] level;
    logic            overflow;
    logic            clr_overflow;

    sa_output_deskew #(
        .Size      (Size),
        .AccWidth  (AccWidth),
        .FifoDepth (FifoDepth)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .acc_in_i       (acc_in),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .level_o        (level),
        .overflow_o     (overflow),
        .clr_overflow_i (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    vec_t q_m[$];
    bit   ov_m;
    vec_t acc_hist [HistLen];
    bit   vld_hist [HistLen];
    int   cyc;

    // Last sampled outputs, for directed checks at specific cycles
    logic            obs_valid;
    vec_t            obs_data;
    logic [LvlW-1:0] obs_level;
    logic            obs_ov;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t r;
        for (int j = 0; j < Size; j++) begin
            r[j] = AccWidth'($urandom);
        end
        return r;
    endfunction

    // One clock cycle: score outputs of the current cycle, then apply new
    // inputs and advance the model to what the coming edge should produce.
    task automatic cycle(input bit v, input vec_t a, input bit rdy, input bit clr);
        vec_t pv;
        bit   push, pop, drop;
        int   base;
        @(negedge clk);
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_level = level;
        obs_ov    = overflow;
        check_eq("out_valid", 64'(out_valid), 64'(q_m.size() > 0));
        check_eq("level", 64'(level), 64'(q_m.size()));
        check_eq("overflow", 64'(overflow), 64'(ov_m));
        if (q_m.size() > 0) check_eq("out_data", 64'(out_data), 64'(q_m[0]));

        in_valid     = v;
        acc_in       = a;
        out_ready    = rdy;
        clr_overflow = clr;
        acc_hist[cyc % HistLen] = a;
        vld_hist[cyc % HistLen] = v;

        push = 1'b0;
        pv   = '0;
        if (cyc >= Size - 1) begin
            base = cyc - (Size - 1);
            if (vld_hist[base % HistLen]) begin
                push = 1'b1;
                for (int j = 0; j < Size; j++) begin
                    pv[j] = acc_hist[(base + j) % HistLen][j];
                end
            end
        end
        pop  = (q_m.size() > 0) && rdy;
        drop = push && (q_m.size() == FifoDepth) && !pop;
        if (pop) void'(q_m.pop_front());
        if (push && !drop) q_m.push_back(pv);
        if (drop) ov_m = 1'b1;
        else if (clr) ov_m = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        q_m.delete();
        ov_m = 1'b0;
        for (int i = 0; i < HistLen; i++) vld_hist[i] = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rand_vec(), rdy, 1'b0);
    endtask

    // Push n back-to-back vectors whose column values are tagged by index
    task automatic burst(input int n, input int tag, input bit rdy);
        vec_t a;
        for (int c = 0; c < n + int'(Size) - 1; c++) begin
            a = rand_vec();
            for (int j = 0; j < Size; j++) begin
                if (c - j >= 0 && c - j < n) a[j] = AccWidth'(16 * (tag + c - j) + j);
            end
            cycle(c < n, a, rdy, 1'b0);
        end
    endtask

    initial begin
        vec_t a;
        cyc          = 0;
        ov_m         = 1'b0;
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        acc_in       = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        for (int i = 0; i < HistLen; i++) vld_hist[i] = 1'b0;
        #2;
        do_reset();

        // Single vector: valid exactly Size cycles after in_valid
        idle(3, 1'b1);
        for (int c = 0; c < Size; c++) begin
            a    = rand_vec();
            a[c] = AccWidth'(16'h0100 + c);
            cycle(c == 0, a, 1'b1, 1'b0);
        end
        check_eq("single_early", 64'(obs_valid), 64'd0);
        idle(1, 1'b1);
        check_eq("single_valid", 64'(obs_valid), 64'd1);
        check_eq("single_data", 64'(obs_data), 64'h0103_0102_0101_0100);
        idle(1, 1'b1);
        check_eq("single_once", 64'(obs_valid), 64'd0);

        // Streaming
        burst(8, 1, 1'b1);
        idle(3, 1'b1);
        check_eq("stream_no_ovf", 64'(obs_ov), 64'd0);

        // Back-pressure then drain
        burst(4, 20, 1'b0);
        idle(3, 1'b0);
        check_eq("bp_level", 64'(obs_level), 64'd4);
        check_eq("bp_valid", 64'(obs_valid), 64'd1);
        idle(4, 1'b1);
        idle(2, 1'b1);
        check_eq("bp_drained", 64'(obs_level), 64'd0);

        // Overflow with full FIFO and no pop
        burst(5, 40, 1'b0);
        idle(2, 1'b0);
        check_eq("ovf_set", 64'(obs_ov), 64'd1);
        check_eq("ovf_level", 64'(obs_level), 64'd4);
        cycle(1'b0, rand_vec(), 1'b0, 1'b1);
        idle(1, 1'b0);
        check_eq("ovf_clear", 64'(obs_ov), 64'd0);

        // Fifth push coincides with a pop: nothing dropped, level stays full
        cycle(1'b1, rand_vec(), 1'b0, 1'b0);
        idle(Size - 2, 1'b0);
        cycle(1'b0, rand_vec(), 1'b1, 1'b0);
        idle(1, 1'b0);
        check_eq("full_pushpop_level", 64'(obs_level), 64'd4);
        check_eq("full_pushpop_ovf", 64'(obs_ov), 64'd0);
        idle(6, 1'b1);

        // Reset mid-flight
        cycle(1'b1, rand_vec(), 1'b1, 1'b0);
        idle(2, 1'b1);
        do_reset();
        idle(2 * Size, 1'b1);

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 99) < 60), rand_vec(),
                  ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 4));
        end
        idle(2 * Size, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
